// File: rtl/muldiv.sv
// Multiply/divide unit feeding a HI/LO register pair: multiply with MUL_LAT cycles of latency,
// radix-2 restoring divide (present only when MULDIV_DIV_EN is defined).
module muldiv #(
    parameter int MUL_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic        hi_write,
    output logic        lo_write,
    output logic [31:0] hi_data,
    output logic [31:0] lo_data
);

`ifdef MULDIV_DIV_EN
    typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2, DONE = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DONE = 2'd3} state_t;
`endif

    state_t      state;
    logic [4:0]  cnt;
    logic        sgn_r;
    logic [31:0] a_r;
    logic [31:0] b_r;
    logic        wr;

    // One shared multiplier: operands come straight from the ports at accept, from registers later
    logic [31:0] ma;
    logic [31:0] mb;
    logic        msgn;
    logic [63:0] ma64;
    logic [63:0] mb64;
    logic [63:0] prod;

    always_comb begin
        ma   = (state == IDLE) ? a : a_r;
        mb   = (state == IDLE) ? b : b_r;
        msgn = (state == IDLE) ? ~op[0] : sgn_r;
        ma64 = {{32{msgn & ma[31]}}, ma};
        mb64 = {{32{msgn & mb[31]}}, mb};
        prod = ma64 * mb64;
    end

`ifdef MULDIV_DIV_EN
    logic [31:0] rem_p;
    logic [31:0] quo_p;
    logic [31:0] dvs_p;
    logic        neg_q;
    logic        neg_r;
    logic [32:0] trial;
    logic [31:0] rem_nx;
    logic [31:0] quo_nx;
    logic [31:0] q_res;
    logic [31:0] r_res;

    function automatic logic [31:0] mag(input logic [31:0] v, input logic s);
        return (s & v[31]) ? -v : v;
    endfunction

    // The shifted-in dividend bit joins the partial remainder before the trial subtraction
    always_comb begin
        trial  = {rem_p, quo_p[31]} - {1'b0, dvs_p};
        rem_nx = trial[32] ? {rem_p[30:0], quo_p[31]} : trial[31:0];
        quo_nx = {quo_p[30:0], ~trial[32]};
        q_res  = neg_q ? -quo_nx : quo_nx;
        r_res  = neg_r ? -rem_nx : rem_nx;
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            sgn_r   <= 1'b0;
            a_r     <= '0;
            b_r     <= '0;
            done    <= 1'b0;
            wr      <= 1'b0;
            hi_data <= '0;
            lo_data <= '0;
`ifdef MULDIV_DIV_EN
            rem_p   <= '0;
            quo_p   <= '0;
            dvs_p   <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            wr   <= 1'b0;
            case (state)
                IDLE: begin
                    if (valid && !flush) begin
                        sgn_r <= ~op[0];
                        a_r   <= a;
                        b_r   <= b;
                        cnt   <= '0;
                        if (!op[1]) begin
                            if (MUL_LAT == 1) begin
                                state   <= DONE;
                                done    <= 1'b1;
                                wr      <= 1'b1;
                                hi_data <= prod[63:32];
                                lo_data <= prod[31:0];
                            end else begin
                                state <= MUL;
                            end
                        end else if (b == 32'd0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
`ifdef MULDIV_DIV_EN
                            state <= DIV;
                            rem_p <= '0;
                            quo_p <= mag(a, ~op[0]);
                            dvs_p <= mag(b, ~op[0]);
                            neg_q <= ~op[0] & (a[31] ^ b[31]);
                            neg_r <= ~op[0] & a[31];
`else
                            state <= DONE;
                            done  <= 1'b1;
`endif
                        end
                    end
                end
                MUL: begin
                    if (flush) begin
                        state <= IDLE;
                    end else if (cnt == 5'(MUL_LAT - 2)) begin
                        state   <= DONE;
                        done    <= 1'b1;
                        wr      <= 1'b1;
                        hi_data <= prod[63:32];
                        lo_data <= prod[31:0];
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
                end
`ifdef MULDIV_DIV_EN
                DIV: begin
                    if (flush) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        rem_p <= rem_nx;
                        quo_p <= quo_nx;
                        cnt   <= cnt + 5'd1;
                        if (cnt == 5'd31) begin
                            state   <= DONE;
                            done    <= 1'b1;
                            wr      <= 1'b1;
                            hi_data <= r_res;
                            lo_data <= q_res;
                        end
                    end
                end
`endif
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign busy     = (state != IDLE);
    assign hi_write = wr;
    assign lo_write = wr;

endmodule

// File: doc/muldiv.md
MULDIV -- requirements
Module: muldiv

Interface
REQ-001 SHALL have parameter MUL_LAT, default 1: cycles from accept to done for multiply; legal range 1..4.
REQ-002 SHALL have port clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port valid  in  1  request strobe; accepted only in IDLE.
REQ-005 SHALL have port op  in  2  operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU.
REQ-006 SHALL have ports a, b  in  32 each  operands (dividend a, divisor b), sampled at accept.
REQ-007 SHALL have port flush  in  1  abort any in-flight operation.
REQ-008 SHALL have port busy  out  1  high whenever state is not IDLE.
REQ-009 SHALL have port done  out  1  one-cycle completion pulse.
REQ-010 SHALL have ports hi_write, lo_write  out  1 each  write enables to the HI/LO register pair.
REQ-011 SHALL have ports hi_data, lo_data  out  32 each  result words; meaningful only while the matching write enable is high.

Function
REQ-012 SHALL implement states IDLE, MUL, DIV, DONE, with busy = (state != IDLE).
REQ-013 SHALL accept a request when valid=1, flush=0 and state=IDLE at a rising edge (accept edge T).
REQ-014 SHALL ignore valid in every other state; no queuing.
REQ-015 SHALL register operands and op at accept.
REQ-016 Multiply: SHALL compute the 64-bit product, signed for MULT and unsigned for MULTU.
REQ-017 Multiply: SHALL output hi_data = product[63:32] and lo_data = product[31:0].
REQ-018 Multiply: SHALL assert done, hi_write and lo_write during cycle T+MUL_LAT.
REQ-019 Divide: SHALL use radix-2 restoring iteration, one quotient bit per cycle, 32 iterations in DIV.
REQ-020 Divide: SHALL assert done, hi_write and lo_write during cycle T+33, with lo_data = quotient and hi_data = remainder.
REQ-021 DIV signed: SHALL divide magnitudes, give the quotient the sign of a XOR b, and give the remainder the sign of a.
REQ-022 DIV signed: SHALL return quotient 0x80000000 and remainder 0 for 0x80000000 / 0xFFFFFFFF.
REQ-023 Divide by zero (b=0): SHALL go straight to DONE; done=1 in cycle T+1 with hi_write=lo_write=0.
REQ-024 In DONE: SHALL assert done for exactly one cycle, then return to IDLE; a new accept is possible at edge T+latency+1.
REQ-025 Outside DONE: SHALL hold done=hi_write=lo_write=0; hi_data and lo_data hold their last values.
REQ-026 Flush: SHALL force IDLE at the next edge with no done and no write, and SHALL have priority over DONE and over accept.
REQ-027 hi_write and lo_write SHALL always be equal; the separate ports exist for the HI/LO register interface.

Reset
REQ-028 While reset=1: SHALL set state=IDLE, busy=0, done=0, hi_write=lo_write=0, hi_data=lo_data=0, iteration counter=0.
REQ-029 Reset asserted mid-operation SHALL abandon the operation with no write, asynchronously.
REQ-030 The first accept SHALL be possible at the first edge after reset deasserts.

Configuration
REQ-031 Macro MULDIV_DIV_EN defined: SHALL include the divider datapath and behave per REQ-019..REQ-023.
REQ-032 Macro MULDIV_DIV_EN undefined: SHALL omit the divider and DIV state; DIV/DIVU complete in DONE at T+1 with done=1 and hi_write=lo_write=0; multiply is unchanged.

Verification
REQ-033 MULT a=0xFFFFFFFF, b=0x00000002, MUL_LAT=1 -> at T+1: done=1, hi=0xFFFFFFFF, lo=0xFFFFFFFE, both writes=1.
REQ-034 MULTU a=0xFFFFFFFF, b=0x00000002 -> hi=0x00000001, lo=0xFFFFFFFE.
REQ-035 DIV a=0xFFFFFFF9 (-7), b=2 -> at T+33: lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); busy=1 from T+1 through T+33.
REQ-036 DIVU a=100, b=0 -> done=1 at T+1 with hi_write=lo_write=0; DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-037 DIVU 100/7 with flush=1 at T+10 -> IDLE at T+11, no done/write; a new MULTU 3*5 accepted at T+11 -> lo=15, hi=0.
REQ-038 Reset pulse at T+5 during DIV -> busy=0 and outputs zero immediately; valid held during busy is never accepted (no second done).
